// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational read ports, two synchronous
// write ports (port 1 wins on collision), optional write-to-read bypass,
// optional hardwired-zero r0 and a per-register busy scoreboard that decode
// sets on issue and writeback clears.
module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic [NRD*AW-1:0]    ra,
  output logic [NRD*WIDTH-1:0] q,
  output logic [NRD-1:0]       rbusy,
  input  logic                 we0,
  input  logic [AW-1:0]        wn0,
  input  logic [WIDTH-1:0]     d0,
  input  logic                 we1,
  input  logic [AW-1:0]        wn1,
  input  logic [WIDTH-1:0]     d1,
  input  logic                 sb_set,
  input  logic [AW-1:0]        sb_n,
  output logic                 busy_any
);

  localparam int DEPTH = 2 ** AW;

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;
  logic [DEPTH-1:0] clr_mask;
  logic [DEPTH-1:0] set_mask;

  // An operation aimed at r0 is silently dropped when r0 is hardwired to zero.
  logic wv0;
  logic wv1;
  logic sv;

  assign wv0 = we0 && !((ZERO_REG != 0) && (wn0 == '0));
  assign wv1 = we1 && !((ZERO_REG != 0) && (wn1 == '0));
  assign sv  = sb_set && !((ZERO_REG != 0) && (sb_n == '0));

  // Next busy vector: writebacks clear, issues set, and a same-cycle issue
  // beats the writeback because it names a newer producer.
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (wv0) clr_mask[wn0] = 1'b1;
    if (wv1) clr_mask[wn1] = 1'b1;
    if (sv)  set_mask[sb_n] = 1'b1;
    busy_next = (busy & ~clr_mask) | set_mask;
  end

  // Storage update; port 1 is applied last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      for (int j = 0; j < DEPTH; j++) begin
        regs[j] <= '0;
      end
    end else begin
      if (wv0) regs[wn0] <= d0;
      if (wv1) regs[wn1] <= d1;
    end
  end

  // Scoreboard state register.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  assign busy_any = |busy;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
    logic             bsy;

    assign addr = ra[i*AW +: AW];

    // Combinational read with optional forwarding of this cycle's writes;
    // a forwarded value is only busy if a new producer issues right now.
    always_comb begin
      data = regs[addr];
      bsy  = busy[addr];
      if (BYPASS != 0) begin
        if (wv1 && (wn1 == addr)) begin
          data = d1;
          bsy  = sv && (sb_n == addr);
        end else if (wv0 && (wn0 == addr)) begin
          data = d0;
          bsy  = sv && (sb_n == addr);
        end
      end
      if ((ZERO_REG != 0) && (addr == '0)) begin
        data = '0;
        bsy  = 1'b0;
      end
    end

    assign q[i*WIDTH +: WIDTH] = data;
    assign rbusy[i]            = bsy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: one default instance (zero reg + bypass) and one
// with ZERO_REG=0/BYPASS=0 share stimulus; a directed table is followed by
// a long randomized run against an array-based reference model.
module tb_regfile_mp;

  localparam int W  = 32;
  localparam int AW = 5;

  logic            clk;
  logic            clrn;
  logic [2*AW-1:0] ra;
  logic [2*W-1:0]  q;
  logic [2*W-1:0]  q_alt;
  logic [1:0]      rbusy;
  logic [1:0]      rbusy_alt;
  logic            we0;
  logic [AW-1:0]   wn0;
  logic [W-1:0]    d0;
  logic            we1;
  logic [AW-1:0]   wn1;
  logic [W-1:0]    d1;
  logic            sb_set;
  logic [AW-1:0]   sb_n;
  logic            busy_any;
  logic            busy_any_alt;

  int vectors;
  int miscompares;

  regfile_mp #(.WIDTH(W), .AW(AW), .NRD(2), .BYPASS(1), .ZERO_REG(1)) dut (
    .clk(clk), .clrn(clrn), .ra(ra), .q(q), .rbusy(rbusy),
    .we0(we0), .wn0(wn0), .d0(d0), .we1(we1), .wn1(wn1), .d1(d1),
    .sb_set(sb_set), .sb_n(sb_n), .busy_any(busy_any)
  );

  regfile_mp #(.WIDTH(W), .AW(AW), .NRD(2), .BYPASS(0), .ZERO_REG(0)) dut_alt (
    .clk(clk), .clrn(clrn), .ra(ra), .q(q_alt), .rbusy(rbusy_alt),
    .we0(we0), .wn0(wn0), .d0(d0), .we1(we1), .wn1(wn1), .d1(d1),
    .sb_set(sb_set), .sb_n(sb_n), .busy_any(busy_any_alt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          clrn;
    logic          we0;
    logic [AW-1:0] wn0;
    logic [W-1:0]  d0;
    logic          we1;
    logic [AW-1:0] wn1;
    logic [W-1:0]  d1;
    logic          sb_set;
    logic [AW-1:0] sb_n;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic          chk;
    logic [W-1:0]  q0;
    logic [W-1:0]  q1;
    logic [1:0]    rb;
    logic          any;
    logic [W-1:0]  alt_q0;
  } vec_t;

  // Reference state: index 0 = zero-reg/bypass config, 1 = plain config.
  logic [W-1:0]  m_reg  [2][32];
  logic [31:0]   m_busy [2];
  bit            cfg_zero [2] = '{1'b1, 1'b0};
  bit            cfg_byp  [2] = '{1'b1, 1'b0};

  function automatic vec_t mk(input logic c, input logic e0, input int a0, input logic [W-1:0] v0,
                              input logic e1, input int a1, input logic [W-1:0] v1,
                              input logic s, input int sn, input int r0, input int r1,
                              input logic ck, input logic [W-1:0] x0, input logic [W-1:0] x1,
                              input logic [1:0] xb, input logic xa, input logic [W-1:0] xalt);
    vec_t v;
    v.clrn = c;  v.we0 = e0; v.wn0 = AW'(a0); v.d0 = v0;
    v.we1 = e1;  v.wn1 = AW'(a1); v.d1 = v1;
    v.sb_set = s; v.sb_n = AW'(sn); v.ra0 = AW'(r0); v.ra1 = AW'(r1);
    v.chk = ck; v.q0 = x0; v.q1 = x1; v.rb = xb; v.any = xa; v.alt_q0 = xalt;
    return v;
  endfunction

  function automatic bit legal(input int c, input logic en, input logic [AW-1:0] a);
    return en && !(cfg_zero[c] && a == 0);
  endfunction

  function automatic logic [W-1:0] exp_q(input int c, input logic [AW-1:0] a);
    if (cfg_zero[c] && a == 0) return '0;
    if (cfg_byp[c]) begin
      if (legal(c, we1, wn1) && wn1 == a) return d1;
      if (legal(c, we0, wn0) && wn0 == a) return d0;
    end
    return m_reg[c][a];
  endfunction

  function automatic logic exp_rb(input int c, input logic [AW-1:0] a);
    if (cfg_zero[c] && a == 0) return 1'b0;
    if (cfg_byp[c] && ((legal(c, we1, wn1) && wn1 == a) || (legal(c, we0, wn0) && wn0 == a)))
      return legal(c, sb_set, sb_n) && sb_n == a;
    return m_busy[c][a];
  endfunction

  task automatic update_model();
    for (int c = 0; c < 2; c++) begin
      if (!clrn) begin
        for (int r = 0; r < 32; r++) m_reg[c][r] = '0;
        m_busy[c] = '0;
      end else begin
        if (legal(c, we0, wn0)) begin m_reg[c][wn0] = d0; m_busy[c][wn0] = 1'b0; end
        if (legal(c, we1, wn1)) begin m_reg[c][wn1] = d1; m_busy[c][wn1] = 1'b0; end
        if (legal(c, sb_set, sb_n)) m_busy[c][sb_n] = 1'b1;
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    clrn = v.clrn; we0 = v.we0; wn0 = v.wn0; d0 = v.d0;
    we1 = v.we1; wn1 = v.wn1; d1 = v.d1;
    sb_set = v.sb_set; sb_n = v.sb_n; ra = {v.ra1, v.ra0};
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic compare_model();
    logic [W-1:0] qq;
    logic         rr;
    for (int c = 0; c < 2; c++) begin
      for (int p = 0; p < 2; p++) begin
        qq = (c == 0) ? q[p*W +: W] : q_alt[p*W +: W];
        rr = (c == 0) ? rbusy[p] : rbusy_alt[p];
        checkOutput($sformatf("model c%0d q%0d", c, p), qq, exp_q(c, ra[p*AW +: AW]));
        checkOutput($sformatf("model c%0d rbusy%0d", c, p), W'(rr), W'(exp_rb(c, ra[p*AW +: AW])));
      end
      checkOutput($sformatf("model c%0d busy_any", c),
                  W'((c == 0) ? busy_any : busy_any_alt), W'(|m_busy[c]));
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, 31));
    return AW'($urandom_range(0, 7));
  endfunction

  vec_t tbl [19];
  vec_t rv;

  initial begin
    vectors = 0;
    miscompares = 0;
    //            clrn we0 wn0 d0           we1 wn1 d1        set sn ra0 ra1 chk q0           q1           rb     any  alt_q0
    tbl[0]  = mk(0, 0, 0,  32'h0,        0, 0,  32'h0,    0, 0,  0,  0,  0, 32'h0,        32'h0,       2'b00, 0, 32'h0);
    tbl[1]  = mk(1, 1, 5,  32'hDEADBEEF, 0, 0,  32'h0,    1, 7,  5,  7,  1, 32'hDEADBEEF, 32'h0,       2'b00, 0, 32'h0);
    tbl[2]  = mk(0, 0, 0,  32'h0,        0, 0,  32'h0,    0, 0,  5,  7,  1, 32'hDEADBEEF, 32'h0,       2'b10, 1, 32'hDEADBEEF);
    tbl[3]  = mk(1, 0, 0,  32'h0,        0, 0,  32'h0,    0, 0,  5,  7,  1, 32'h0,        32'h0,       2'b00, 0, 32'h0);
    tbl[4]  = mk(1, 1, 3,  32'h11,       1, 4,  32'h22,   0, 0,  3,  4,  1, 32'h11,       32'h22,      2'b00, 0, 32'h0);
    tbl[5]  = mk(1, 0, 0,  32'h0,        0, 0,  32'h0,    0, 0,  3,  4,  1, 32'h11,       32'h22,      2'b00, 0, 32'h11);
    tbl[6]  = mk(1, 1, 6,  32'hAA,       1, 6,  32'hBB,   0, 0,  6,  6,  1, 32'hBB,       32'hBB,      2'b00, 0, 32'h0);
    tbl[7]  = mk(1, 0, 0,  32'h0,        0, 0,  32'h0,    0, 0,  6,  0,  1, 32'hBB,       32'h0,       2'b00, 0, 32'hBB);
    tbl[8]  = mk(1, 1, 0,  32'hFFFFFFFF, 0, 0,  32'h0,    1, 0,  0,  6,  1, 32'h0,        32'hBB,      2'b00, 0, 32'h0);
    tbl[9]  = mk(1, 0, 0,  32'h0,        0, 0,  32'h0,    0, 0,  0,  0,  1, 32'h0,        32'h0,       2'b00, 0, 32'hFFFFFFFF);
    tbl[10] = mk(1, 1, 9,  32'h1,        0, 0,  32'h0,    0, 0,  9,  0,  1, 32'h1,        32'h0,       2'b00, 0, 32'h0);
    tbl[11] = mk(1, 1, 9,  32'h55,       0, 0,  32'h0,    0, 0,  9,  0,  1, 32'h55,       32'h0,       2'b00, 0, 32'h1);
    tbl[12] = mk(1, 0, 0,  32'h0,        0, 0,  32'h0,    0, 0,  9,  0,  1, 32'h55,       32'h0,       2'b00, 0, 32'h55);
    tbl[13] = mk(1, 0, 0,  32'h0,        0, 0,  32'h0,    1, 12, 12, 12, 1, 32'h0,        32'h0,       2'b00, 0, 32'h0);
    tbl[14] = mk(1, 0, 0,  32'h0,        0, 0,  32'h0,    0, 0,  12, 12, 1, 32'h0,        32'h0,       2'b11, 1, 32'h0);
    tbl[15] = mk(1, 1, 12, 32'h77,       0, 0,  32'h0,    0, 0,  12, 12, 1, 32'h77,       32'h77,      2'b00, 1, 32'h0);
    tbl[16] = mk(1, 0, 0,  32'h0,        0, 0,  32'h0,    0, 0,  12, 12, 1, 32'h77,       32'h77,      2'b00, 0, 32'h77);
    tbl[17] = mk(1, 0, 0,  32'h0,        1, 12, 32'h99,   1, 12, 12, 12, 1, 32'h99,       32'h99,      2'b11, 0, 32'h77);
    tbl[18] = mk(1, 0, 0,  32'h0,        0, 0,  32'h0,    0, 0,  12, 12, 1, 32'h99,       32'h99,      2'b11, 1, 32'h99);

    $display("[TB] directed table");
    for (int i = 0; i < 19; i++) begin
      applyStimulus(tbl[i]);
      #4;
      if (tbl[i].chk) begin
        checkOutput($sformatf("vec%0d q0", i), q[W-1:0], tbl[i].q0);
        checkOutput($sformatf("vec%0d q1", i), q[2*W-1:W], tbl[i].q1);
        checkOutput($sformatf("vec%0d rbusy", i), W'(rbusy), W'(tbl[i].rb));
        checkOutput($sformatf("vec%0d busy_any", i), W'(busy_any), W'(tbl[i].any));
        checkOutput($sformatf("vec%0d alt q0", i), q_alt[W-1:0], tbl[i].alt_q0);
        compare_model();
      end
      @(posedge clk);
      update_model();
      #1;
    end

    $display("[TB] random regression");
    for (int cyc = 0; cyc < 10000; cyc++) begin
      rv.clrn   = !((cyc % 997) == 500 || $urandom_range(0, 299) == 0);
      rv.we0    = 1'($urandom_range(0, 1));
      rv.wn0    = rand_addr();
      rv.d0     = $urandom;
      rv.we1    = 1'($urandom_range(0, 1));
      rv.wn1    = rand_addr();
      rv.d1     = $urandom;
      rv.sb_set = 1'($urandom_range(0, 1));
      rv.sb_n   = rand_addr();
      rv.ra0    = rand_addr();
      rv.ra1    = rand_addr();
      rv.chk    = 1'b0;
      rv.q0 = '0; rv.q1 = '0; rv.rb = '0; rv.any = 1'b0; rv.alt_q0 = '0;
      applyStimulus(rv);
      #4;
      compare_model();
      @(posedge clk);
      update_model();
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the single-write-port CPU register file.
- Provides WIDTH x 2**AW storage with NRD combinational read ports, two synchronous write ports, optional write-to-read bypass and an optional hardwired-zero register 0.
- Adds a per-register busy scoreboard (set on issue, cleared on writeback) so the pipelined/dual-issue core can detect RAW hazards.
- Sits between decode (reads, busy set) and writeback (writes).

Parameters:
- WIDTH, 32: data bits per register.
- AW, 5: register address bits; DEPTH = 2**AW.
- NRD, 2: number of read ports (1..4).
- BYPASS, 1: 1 = a read of a register being written this cycle returns the write data; 0 = a read returns the stored value.
- ZERO_REG, 1: 1 = register 0 always reads 0, is never written and is never busy; 0 = register 0 is ordinary.

Ports:
- clk  in  1  clock; all state updates on posedge.
- clrn  in  1  reset. Synchronous, active-low: sampled on posedge clk.
- ra  in  NRD*AW  read addresses; port i = ra[i*AW +: AW].
- q  out  NRD*WIDTH  read data; port i = q[i*WIDTH +: WIDTH].
- rbusy  out  NRD  busy flag for each read port's register.
- we0  in  1  write enable, port 0.
- wn0  in  AW  write address, port 0.
- d0  in  WIDTH  write data, port 0.
- we1  in  1  write enable, port 1.
- wn1  in  AW  write address, port 1.
- d1  in  WIDTH  write data, port 1.
- sb_set  in  1  mark register sb_n busy (instruction issued).
- sb_n  in  AW  register to mark busy.
- busy_any  out  1  OR of all busy bits.

Behaviour:
- Reset: on posedge clk with clrn==0, every register is 0 and every busy bit is 0. All other inputs are ignored that cycle. Reset mid-operation discards pending writes and sets.
- Outputs after reset: q=0 for all ports, rbusy=0, busy_any=0.
- Read path: purely combinational, zero latency; NRD ports are fully independent.
- ZERO_REG=1 and ra_i==0: q_i=0 and rbusy_i=0 regardless of any write or set.
- Write, port k: on posedge with clrn==1, if we_k==1 (and wn_k!=0 when ZERO_REG=1), reg[wn_k] <= d_k and busy[wn_k] <= 0.
- Write collision: both ports enabled with wn0==wn1 stores d1 (port 1 wins); the busy bit is cleared once.
- Scoreboard set: sb_set==1 (and sb_n!=0 when ZERO_REG=1) gives busy[sb_n] <= 1.
- Set and write on the same register in the same cycle: the set wins and busy ends at 1 (a new producer was issued).
- Redundant operations: a set on an already-busy register keeps it at 1; a write to a non-busy register is legal and leaves it at 0.
- Bypass, BYPASS=1: if a read address matches an enabled, legal write this cycle, q_i = that write data, with port 1 taking priority over port 0. rbusy_i is then 0 unless sb_set targets the same register this cycle.
- Bypass, BYPASS=0: q_i and rbusy_i reflect stored state only; the write is visible from the next cycle.
- rbusy_i does not reflect an sb_set issued in the same cycle, except via the bypass rule above.
- busy_any reflects stored busy bits only (registered state, no combinational input path).
- Address width: addresses are AW bits wide, so every value is in range and no checking is needed.

Test Plan:
- Reset sequence: write 0xDEADBEEF to r5 and set r7 busy, then hold clrn=0 for one posedge -> q(r5)=0, rbusy(r7)=0, busy_any=0.
- Dual write: we0=1, wn0=3, d0=0x11 together with we1=1, wn1=4, d1=0x22 -> next cycle q(r3)=0x11 and q(r4)=0x22. Then with wn0=wn1=6, d0=0xAA, d1=0xBB -> q(r6)=0xBB.
- Zero register (ZERO_REG=1): write 0xFFFFFFFF to r0 and sb_set r0 -> q(r0)=0, rbusy=0, busy_any=0. With ZERO_REG=0, the same stimulus gives q(r0)=0xFFFFFFFF.
- Bypass (BYPASS=1): r9=0x1 stored, write 0x55 to r9 while ra0=9 -> q0=0x55 in the same cycle. With BYPASS=0 -> q0=0x1 that cycle, then 0x55 the next cycle.
- Scoreboard: sb_set r12 -> next cycle rbusy(r12)=1 and busy_any=1. Write r12=0x77 -> next cycle rbusy=0 and busy_any=0. sb_set and a write to r12 in the same cycle -> busy stays 1 and q(r12)=written value.
- Random regression: random reads, writes and sets on all ports over 10k cycles with periodic resets, compared against a behavioural model with port-1 priority and set-over-clear.
